// File: rtl/pong_pkg.sv
// Shared definitions for the Pong push-button conditioning path.
package pong_pkg;

  typedef enum logic [2:0] {
    WAIT_REL  = 3'd0,
    IDLE      = 3'd1,
    PRESS_CHK = 3'd2,
    HELD      = 3'd3,
    REL_CHK   = 3'd4
  } chan_state_t;

  localparam int DEB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/input_debounce.sv
// One button channel: 2-FF synchronizer, debounce FSM and a registered
// single-cycle fire output on each accepted press.
module input_debounce
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic fire
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_a;
  logic             s;
  chan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_done;

  assign cnt_inc  = cnt + CNT_ONE;
  assign cnt_done = (cnt_inc == CNT_LAST);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= raw;
      s      <= sync_a;
    end
  end

  // WAIT_REL after reset forces a button held through reset to be released first.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= WAIT_REL;
      cnt   <= '0;
      fire  <= 1'b0;
    end else begin
      fire <= 1'b0;
      case (state)
        WAIT_REL: begin
          if (s) begin
            cnt <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        IDLE: begin
          if (s) begin
            if (DEB_CYCLES == 1) begin
              state <= HELD;
              cnt   <= '0;
              fire  <= 1'b1;
            end else begin
              state <= PRESS_CHK;
              cnt   <= CNT_ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= HELD;
            cnt   <= '0;
            fire  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (!s) begin
            if (DEB_CYCLES == 1) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= REL_CHK;
              cnt   <= CNT_ONE;
            end
          end
        end
        REL_CHK: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= WAIT_REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pong_input_conditioner.sv
// Conditions the serve (b) and paddle (p) buttons into one pulse per press,
// with a lockout window that swallows paddle presses shortly after a hit.
module pong_input_conditioner
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
  parameter int LOCK_CYCLES = 0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic b_raw,
  input  logic p_raw,
  output logic b_pulse,
  output logic p_pulse,
  output logic p_locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 2);
  localparam logic LOCK_EN = (LOCK_CYCLES > 0);
  localparam logic [LOCK_W-1:0] LOCK_RELOAD = (LOCK_CYCLES > 0) ? LOCK_W'(LOCK_CYCLES - 1) : '0;
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

  logic              b_fire;
  logic              p_fire;
  logic [LOCK_W-1:0] lock_cnt;
  logic              was_locked;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_b_chan (
    .Clk  (Clk),
    .Rst  (Rst),
    .raw  (b_raw),
    .fire (b_fire)
  );

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_p_chan (
    .Clk  (Clk),
    .Rst  (Rst),
    .raw  (p_raw),
    .fire (p_fire)
  );

  // The lockout counter logically holds LOCK_CYCLES during the pulse cycle;
  // the register stores one less and the pulse itself supplies that cycle.
  assign b_pulse  = b_fire;
  assign p_pulse  = p_fire & ~was_locked;
  assign p_locked = (lock_cnt != '0) | (p_pulse & LOCK_EN);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lock_cnt   <= '0;
      was_locked <= 1'b0;
    end else begin
      was_locked <= p_locked;
      if (p_pulse && LOCK_EN) begin
        lock_cnt <= LOCK_RELOAD;
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - LOCK_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Directed and randomized bench for pong_input_conditioner, checked every
// cycle against a run-length reference model of the button conditioning.
module tb_pong_input_conditioner;

  localparam int DEB  = 4;
  localparam int LOCK = 10;

  logic Clk = 1'b0;
  logic Rst;
  logic b_raw = 1'b0;
  logic p_raw = 1'b0;
  logic b_pulse;
  logic p_pulse;
  logic p_locked;

  int checks = 0;
  int errors = 0;

  logic q_b[$];
  logic q_p[$];
  logic lvl_b, lvl_p;
  int   run_b, run_p;
  int   lock_rem;
  logic exp_b, exp_p, exp_locked;

  int nb, np, fb, fp, nb2, np2, fb2, fp2;

  pong_input_conditioner #(
    .DEB_CYCLES  (DEB),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .b_raw    (b_raw),
    .p_raw    (p_raw),
    .b_pulse  (b_pulse),
    .p_pulse  (p_pulse),
    .p_locked (p_locked)
  );

  always #5 Clk = ~Clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model treats each button as a level that flips after DEB consecutive
  // samples disagreeing with it; it starts as "pressed" so a release is needed.
  task automatic model_reset();
    q_b.delete(); q_b.push_back(1'b0); q_b.push_back(1'b0);
    q_p.delete(); q_p.push_back(1'b0); q_p.push_back(1'b0);
    lvl_b = 1'b1; lvl_p = 1'b1;
    run_b = 0;    run_p = 0;
    lock_rem = 0;
    exp_b = 1'b0; exp_p = 1'b0; exp_locked = 1'b0;
  endtask

  function automatic logic deb_update(input logic seen, inout logic lvl, inout int run);
    logic f;
    f = 1'b0;
    if (seen != lvl) run++;
    else run = 0;
    if (run == DEB) begin
      lvl = seen;
      run = 0;
      f   = seen;
    end
    return f;
  endfunction

  task automatic model_step();
    logic sb, sp, fire_b, fire_p;
    q_b.push_back(b_raw);
    q_p.push_back(p_raw);
    sb = q_b.pop_front();
    sp = q_p.pop_front();
    fire_b = deb_update(sb, lvl_b, run_b);
    fire_p = deb_update(sp, lvl_p, run_p);
    exp_b = fire_b;
    exp_p = fire_p && (lock_rem == 0);
    if (exp_p) lock_rem = LOCK;
    else if (lock_rem > 0) lock_rem--;
    exp_locked = (lock_rem != 0);
  endtask

  task automatic check_output();
    check_bit("b_pulse", b_pulse, exp_b);
    check_bit("p_pulse", p_pulse, exp_p);
    check_bit("p_locked", p_locked, exp_locked);
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst) model_step();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic b, input logic p, input int n,
                                output int cnt_b, output int cnt_p,
                                output int first_b, output int first_p);
    b_raw = b;
    p_raw = p;
    cnt_b = 0; cnt_p = 0; first_b = -1; first_p = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (b_pulse === 1'b1) begin
        if (cnt_b == 0) first_b = i;
        cnt_b++;
      end
      if (p_pulse === 1'b1) begin
        if (cnt_p == 0) first_p = i;
        cnt_p++;
      end
    end
  endtask

  task automatic enter_reset();
    Rst = 1'b0;
    model_reset();
    #1;
    check_output();
  endtask

  task automatic leave_reset();
    tick();
    tick();
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    model_reset();
    Rst   = 1'b1;
    b_raw = 1'b1;
    #1;
    Rst = 1'b0;
    #11;
    $display("[TB] reset state");
    check_output();
    @(negedge Clk);
    Rst = 1'b1;

    $display("[TB] test 1: serve held through reset");
    apply_stimulus(1, 0, 20, nb, np, fb, fp);
    check_int("t1_held_through_reset", nb, 0);
    apply_stimulus(0, 0, 6, nb, np, fb, fp);
    apply_stimulus(1, 0, 10, nb, np, fb, fp);
    check_int("t1_press_count", nb, 1);
    check_int("t1_press_latency", fb, 5);

    $display("[TB] test 2: clean and long serve presses");
    apply_stimulus(0, 0, 8, nb, np, fb, fp);
    apply_stimulus(1, 0, 12, nb, np, fb, fp);
    check_int("t2_clean_count", nb, 1);
    check_int("t2_clean_latency", fb, 5);
    apply_stimulus(0, 0, 8, nb, np, fb, fp);
    apply_stimulus(1, 0, 50, nb, np, fb, fp);
    check_int("t2_long_hold_count", nb, 1);
    apply_stimulus(0, 0, 8, nb, np, fb, fp);

    $display("[TB] test 3: bouncing serve");
    apply_stimulus(1, 0, 2, nb, np, fb, fp);
    apply_stimulus(0, 0, 2, nb2, np2, fb2, fp2);
    check_int("t3_bounce_count", nb + nb2, 0);
    apply_stimulus(1, 0, 12, nb, np, fb, fp);
    check_int("t3_settled_count", nb, 1);
    check_int("t3_settled_latency", fb, 5);
    apply_stimulus(0, 0, 8, nb, np, fb, fp);

    $display("[TB] test 4: paddle lockout");
    apply_stimulus(0, 1, 6, nb, np, fb, fp);
    check_int("t4_first_hit_count", np, 1);
    check_int("t4_first_hit_latency", fp, 5);
    check_bit("t4_locked_on_hit", p_locked, 1'b1);
    apply_stimulus(0, 0, 4, nb, np, fb, fp);
    apply_stimulus(0, 1, 12, nb, np, fb, fp);
    check_int("t4_swallowed_count", np, 0);
    check_bit("t4_lock_expired", p_locked, 1'b0);
    apply_stimulus(0, 0, 8, nb, np, fb, fp);
    apply_stimulus(0, 1, 8, nb, np, fb, fp);
    check_int("t4_third_hit_count", np, 1);
    check_int("t4_third_hit_latency", fp, 5);

    $display("[TB] test 5: simultaneous presses");
    apply_stimulus(0, 0, 12, nb, np, fb, fp);
    apply_stimulus(1, 1, 8, nb, np, fb, fp);
    check_int("t5_b_count", nb, 1);
    check_int("t5_p_count", np, 1);
    check_int("t5_b_latency", fb, 5);
    check_int("t5_p_latency", fp, 5);

    $display("[TB] test 6: reset mid-operation");
    apply_stimulus(0, 0, 12, nb, np, fb, fp);
    apply_stimulus(0, 1, 6, nb, np, fb, fp);
    check_bit("t6_pulse_before_reset", p_pulse, 1'b1);
    enter_reset();
    check_bit("t6_pulse_dropped", p_pulse, 1'b0);
    check_bit("t6_lock_cleared", p_locked, 1'b0);
    leave_reset();
    apply_stimulus(0, 1, 10, nb, np, fb, fp);
    check_int("t6_held_after_reset", np, 0);
    apply_stimulus(0, 0, 8, nb, np, fb, fp);
    apply_stimulus(0, 1, 5, nb, np, fb, fp);
    enter_reset();
    leave_reset();
    apply_stimulus(0, 1, 20, nb, np, fb, fp);
    check_int("t6_no_pulse_until_release", np, 0);
    apply_stimulus(0, 0, 6, nb, np, fb, fp);
    apply_stimulus(0, 1, 8, nb, np, fb, fp);
    check_int("t6_repress_count", np, 1);
    check_int("t6_repress_latency", fp, 5);

    $display("[TB] randomized presses");
    apply_stimulus(0, 0, 12, nb, np, fb, fp);
    for (int k = 0; k < 80; k++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 9)), nb, np, fb, fp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_input_conditioner.md
Name: pong_input_conditioner

Overview:
Conditions the two raw push-button inputs of the Pong game: serve/start (b) and paddle hit (p).
- Each input passes through a 2-FF synchronizer, then a debounce counter, then a one-shot stage.
- Output is exactly one single-cycle pulse per physical press.
- It sits directly upstream of the game Controller; its pulses drive the Controller's b and p inputs.
- A paddle lockout window stops repeated p presses from registering as multiple hits.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a press or release. Must be ≥ 1. Benches override it to 4.
- LOCK_CYCLES, 0: number of cycles after a p_pulse during which further paddle presses are swallowed. 0 disables the lockout.
- CNT_W, $clog2(DEB_CYCLES+1): debounce counter width (derived).
- LOCK_W, $clog2(LOCK_CYCLES+2): lockout counter width (derived).

Ports:
- Clk, input, 1: system clock; all state changes on its rising edge.
- Rst, input, 1: reset, asynchronous, active-low. Rst=0 resets immediately; deassertion is sampled on Clk.
- b_raw, input, 1: serve button, asynchronous, active-high, bouncy.
- p_raw, input, 1: paddle button, asynchronous, active-high, bouncy.
- b_pulse, output, 1: one-cycle pulse per accepted serve press; drives Controller b.
- p_pulse, output, 1: one-cycle pulse per accepted paddle press outside lockout; drives Controller p.
- p_locked, output, 1: high while the paddle lockout counter is non-zero.

Behaviour:
- Reset values (Rst=0):
  - Sync FFs = 0; debounce counters = 0; lockout counter = 0.
  - b_pulse = 0, p_pulse = 0, p_locked = 0.
  - Both channel FSMs go to WAIT_REL.
- Synchronizer: s = second FF of a 2-FF chain on the raw input. The FSM only ever looks at s.
- Channel FSM states: WAIT_REL, IDLE, PRESS_CHK, HELD, REL_CHK. Counter cnt counts consecutive cycles of the qualifying s value.
  - WAIT_REL:
    - s=1 → cnt=0 (stay).
    - s=0 → cnt++. When the count of consecutive s=0 samples reaches DEB_CYCLES, go to IDLE.
    - Effect: a button held through reset never pulses; it must be released and pressed again.
  - IDLE:
    - s=1 → PRESS_CHK with cnt=1. If DEB_CYCLES=1, go directly to HELD and fire.
  - PRESS_CHK:
    - s=0 → IDLE, cnt=0. A glitch shorter than DEB_CYCLES at s produces no pulse.
    - s=1 → cnt++. On the count reaching DEB_CYCLES, go to HELD and fire.
  - HELD:
    - No output while held; there is no auto-repeat.
    - s=0 → REL_CHK with cnt=1.
  - REL_CHK:
    - s=1 → HELD.
    - DEB_CYCLES consecutive s=0 samples → IDLE.
- Fire: the registered pulse output goes high for exactly one cycle, on the same edge the FSM enters HELD.
- Latency:
  - E0 is the first Clk edge that samples raw=1.
  - s goes high after edge E1.
  - The pulse is high from edge E(DEB_CYCLES+1) to edge E(DEB_CYCLES+2).
  - With DEB_CYCLES=4, the pulse is high between E5 and E6.
- Paddle lockout:
  - When p_pulse fires and LOCK_CYCLES>0, the lockout counter loads LOCK_CYCLES on the same edge.
  - The counter decrements by 1 per cycle down to 0.
  - p_locked = (counter ≠ 0).
  - A p fire event while p_locked=1: the FSM still moves to HELD (the press is consumed), p_pulse stays 0, and the counter is not reloaded.
  - The lockout expires on schedule while the button is held. Pulses occur only on new presses.
- Simultaneous events:
  - The b and p channels are fully independent; both pulses may be high in the same cycle.
  - The lockout affects p only.
- Reset mid-operation: asynchronous return to reset values. Any pulse in flight is dropped, and the lockout is cleared.

Decomposition:
- Shared package pong_pkg holds:
  - the channel state encoding (localparams WAIT_REL=0, IDLE=1, PRESS_CHK=2, HELD=3, REL_CHK=4, 3 bits);
  - the default DEB_CYCLES constant.
- One sub-module, input_debounce, contains the synchronizer, FSM, counter and registered fire output for one channel. It has parameter DEB_CYCLES and ports Clk, Rst, raw, fire.
- Top level: two input_debounce instances plus the lockout counter and the p_pulse gating.

Test Plan (DEB_CYCLES=4, LOCK_CYCLES=10, 10 ns clock):
1. Hold b_raw=1 through reset, release Rst, keep b_raw=1 for 20 cycles → b_pulse stays 0. Then b_raw=0 for 6 cycles, then 1 → b_pulse high exactly 1 cycle, DEB_CYCLES+1 edges after the first edge sampling 1.
2. Clean b press of 12 cycles → exactly one b_pulse, high on edge E5 and low on edge E6. Holding b_raw for 50 cycles gives still exactly one pulse.
3. Bounce b_raw 1/0/1 with each level lasting 2 cycles, then hold 1 → no pulse during the bounce. One pulse 5 edges after the final rise is sampled.
4. Press p (accepted) → p_pulse=1 and p_locked=1 for 10 cycles. A second clean press accepted 6 cycles later → p_pulse stays 0. A third press after p_locked falls → p_pulse=1 again.
5. b and p pressed on the same edge → b_pulse and p_pulse both high in the same cycle.
6. Assert Rst=0 during a PRESS_CHK of p at cnt=3 → p_pulse and p_locked are 0 immediately. After reset, p held → no pulse until p is released for ≥4 cycles and pressed again.
